// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: datapath-side fetch handshake plus instruction-memory
// request/response signals. The master modport is the fetch unit's view.
interface instr_fetch_unit_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] pc;
   logic            pc_valid;
   logic            flush;
   logic            instr_ready;
   logic [XLEN-1:0] instruction;
   logic            instr_valid;
   logic            fetch_fault;
   logic            misaligned;
   logic            mem_req;
   logic [XLEN-1:0] mem_addr;
   logic            mem_ready;
   logic [XLEN-1:0] mem_rdata;
   logic            mem_rvalid;

   modport master (
      input  pc, pc_valid, flush, instr_ready, mem_ready, mem_rdata, mem_rvalid,
      output instruction, instr_valid, fetch_fault, misaligned, mem_req, mem_addr
   );

   modport slave (
      output pc, pc_valid, flush, instr_ready, mem_ready, mem_rdata, mem_rvalid,
      input  instruction, instr_valid, fetch_fault, misaligned, mem_req, mem_addr
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding memory read with timeout, flush and drain of
// owed responses. Define MISALIGN_TRAP_EN to trap misaligned PCs instead of masking them.
module instr_fetch_unit #(
   parameter int              XLEN           = 32,
   parameter int              TIMEOUT_CYCLES = 16,
   parameter logic [XLEN-1:0] NOP_WORD       = XLEN'(32'h0000_0013)
) (
   input  logic                clk,
   input  logic                reset,
   instr_fetch_unit_if.master  io_bus
);

   localparam int            TW         = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

   state_t          r_state,    w_state_next;
   logic [XLEN-1:0] r_addr,     w_addr_next;
   logic [XLEN-1:0] r_instr,    w_instr_next;
   logic            r_valid,    w_valid_next;
   logic            r_fault,    w_fault_next;
   logic            r_misal,    w_misal_next;
   logic            r_mem_req,  w_mem_req_next;
   logic [XLEN-1:0] r_mem_addr, w_mem_addr_next;
   logic [TW-1:0]   r_timer,    w_timer_next;
   logic            r_pend,     w_pend_next;
   logic            w_launch;
   logic [XLEN-1:0] w_launch_addr;
   logic            w_handshake;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_instr    <= NOP_WORD;
         r_valid    <= 1'b0;
         r_fault    <= 1'b0;
         r_misal    <= 1'b0;
         r_mem_req  <= 1'b0;
         r_mem_addr <= '0;
         r_timer    <= '0;
         r_pend     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_addr     <= w_addr_next;
         r_instr    <= w_instr_next;
         r_valid    <= w_valid_next;
         r_fault    <= w_fault_next;
         r_misal    <= w_misal_next;
         r_mem_req  <= w_mem_req_next;
         r_mem_addr <= w_mem_addr_next;
         r_timer    <= w_timer_next;
         r_pend     <= w_pend_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_addr_next     = r_addr;
      w_instr_next    = r_instr;
      w_valid_next    = r_valid;
      w_fault_next    = r_fault;
      w_misal_next    = r_misal;
      w_mem_req_next  = r_mem_req;
      w_mem_addr_next = r_mem_addr;
      w_timer_next    = r_timer;
      w_pend_next     = r_pend;
      w_launch        = 1'b0;
      w_launch_addr   = r_addr;
      w_handshake     = r_valid & io_bus.instr_ready;

      case (r_state)
         S_IDLE: begin
            if (!io_bus.flush && io_bus.pc_valid) begin
               w_launch      = 1'b1;
               w_launch_addr = io_bus.pc;
            end
         end
         S_REQ: begin
            // A request accepted in the flush cycle still owes a response, so drain it.
            if (io_bus.mem_ready) begin
               w_mem_req_next = 1'b0;
               w_timer_next   = '0;
               w_state_next   = io_bus.flush ? S_DRAIN : S_WAIT;
            end else if (io_bus.flush) begin
               w_mem_req_next = 1'b0;
               w_state_next   = S_IDLE;
            end
         end
         S_WAIT: begin
            if (io_bus.flush) begin
               w_valid_next = 1'b0;
               w_fault_next = 1'b0;
               w_misal_next = 1'b0;
               w_state_next = io_bus.mem_rvalid ? S_IDLE : S_DRAIN;
            end else if (io_bus.mem_rvalid) begin
               w_instr_next = io_bus.mem_rdata;
               w_valid_next = 1'b1;
               w_fault_next = 1'b0;
               w_state_next = S_HOLD;
            end else if (r_timer == TIMER_LAST) begin
               w_instr_next = NOP_WORD;
               w_valid_next = 1'b1;
               w_fault_next = 1'b1;
               w_state_next = S_DRAIN;
            end else begin
               w_timer_next = r_timer + 1'b1;
            end
         end
         S_HOLD: begin
            if (io_bus.flush || w_handshake) begin
               w_valid_next = 1'b0;
               w_fault_next = 1'b0;
               w_misal_next = 1'b0;
               w_state_next = S_IDLE;
               if (!io_bus.flush && io_bus.pc_valid) begin
                  w_launch      = 1'b1;
                  w_launch_addr = io_bus.pc;
               end
            end
         end
         S_DRAIN: begin
            // The fault word may still be held here while the late response is owed.
            if (io_bus.flush) begin
               w_valid_next = 1'b0;
               w_fault_next = 1'b0;
               w_misal_next = 1'b0;
               w_pend_next  = 1'b0;
               if (io_bus.mem_rvalid) w_state_next = S_IDLE;
            end else begin
               if (w_handshake) begin
                  w_valid_next = 1'b0;
                  w_fault_next = 1'b0;
                  w_misal_next = 1'b0;
               end
               if (io_bus.pc_valid && !r_pend && (!r_valid || io_bus.instr_ready)) begin
                  w_pend_next = 1'b1;
                  w_addr_next = io_bus.pc;
               end
               if (io_bus.mem_rvalid) begin
                  if (w_valid_next) begin
                     w_state_next = S_HOLD;
                  end else if (w_pend_next) begin
                     w_launch      = 1'b1;
                     w_launch_addr = w_addr_next;
                  end else begin
                     w_state_next = S_IDLE;
                  end
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase

      if (w_launch) begin
         w_addr_next = w_launch_addr;
         if (TRAP_EN && (w_launch_addr[1:0] != 2'b00)) begin
            w_instr_next = NOP_WORD;
            w_valid_next = 1'b1;
            w_fault_next = 1'b0;
            w_misal_next = 1'b1;
            w_state_next = S_HOLD;
         end else begin
            w_mem_req_next  = 1'b1;
            w_mem_addr_next = {w_launch_addr[XLEN-1:2], 2'b00};
            w_state_next    = S_REQ;
         end
      end
      if (w_state_next != S_DRAIN) w_pend_next = 1'b0;
   end

   assign io_bus.instruction = r_instr;
   assign io_bus.instr_valid = r_valid;
   assign io_bus.fetch_fault = r_fault;
   assign io_bus.misaligned  = r_misal;
   assign io_bus.mem_req     = r_mem_req;
   assign io_bus.mem_addr    = r_mem_addr;

endmodule
